uart_mmio: RTL

- Single-clock, memory-mapped UART controller sitting on the CPU data-memory bus beside the RAM and the timer/LED peripheral.
- The data memory routes peripheral-space accesses at 0x40000018 and above here.
- The controller returns read data combinationally to the memory's read mux.
- TX and RX are 8N1 serial with a parameterised bit period; status is exposed to software by polling.

---
 rtl/uart_mmio.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers on the data bus, polled status,
// independent transmit and receive state machines sharing one bit period.
module uart_mmio #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic sel_txd, sel_rxd, sel_con;
  logic tx_req, rx_clear, con_wr;

  assign sel_txd  = (addr == BASE_ADDR);
  assign sel_rxd  = (addr == BASE_ADDR + 32'd4);
  assign sel_con  = (addr == BASE_ADDR + 32'd8);
  assign tx_req   = wr && sel_txd;
  assign rx_clear = rd && sel_rxd;
  assign con_wr   = wr && sel_con;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  state_t      tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        txd_n;
  logic        tx_busy;

  assign tx_busy = (tx_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      uart_txd <= txd_n;
    end
  end

  // The shift register always holds the current data bit in [0], so the next
  // bit to drive is [1] at each bit boundary.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    txd_n      = uart_txd;
    case (tx_state)
      S_IDLE: begin
        txd_n = 1'b1;
        if (tx_req) begin
          tx_shift_n = wdata[7:0];
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          txd_n      = 1'b0;
          tx_state_n = S_START;
        end
      end
      S_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          txd_n      = tx_shift[0];
          tx_state_n = S_DATA;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = S_STOP;
          end else begin
            tx_idx_n   = tx_idx + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = S_IDLE;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  logic        rx_meta, rx_s;
  state_t      rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        rx_valid, overrun, frame_err;
  logic        rx_ok, rx_bad;

  assign rx_ok  = rx_done && rx_s;
  assign rx_bad = rx_done && !rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= uart_rxd;
      rx_s     <= rx_meta;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Start bit is re-checked half a bit in; every later sample lands a whole
  // bit period after the previous one.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (!rx_s) begin
          rx_cnt_n   = '0;
          rx_state_n = S_START;
        end
      end
      S_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_s ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          if (rx_idx == 3'd7) begin
            rx_state_n = S_STOP;
          end else begin
            rx_idx_n = rx_idx + 3'd1;
          end
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_done    = 1'b1;
          rx_state_n = S_IDLE;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // A completing byte always beats a same-edge software clear of any flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_ok) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_clear) begin
        rx_valid <= 1'b0;
      end
      if (rx_ok && rx_valid && !rx_clear) begin
        overrun <= 1'b1;
      end else if (con_wr && wdata[4]) begin
        overrun <= 1'b0;
      end
      if (rx_bad) begin
        frame_err <= 1'b1;
      end else if (con_wr && wdata[5]) begin
        frame_err <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_rxd) begin
        rdata = {24'b0, rx_data};
      end else if (sel_con) begin
        rdata = {26'b0, frame_err, overrun, tx_busy, rx_valid, 2'b00};
      end
    end
  end

endmodule
